// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache with a writeback/fetch miss FSM.
// Define DCACHE_STATS_EN to add the HIT_COUNT/MISS_COUNT counters.
module dcache_controller #(
    parameter int NUM_SETS = 8,
    parameter int BLOCK_WORDS = 4,
    localparam int INDEX_W = $clog2(NUM_SETS),
    localparam int OFFSET_W = $clog2(BLOCK_WORDS),
    localparam int TAG_W = 30 - INDEX_W - OFFSET_W,
    localparam int BLK_W = 32 * BLOCK_WORDS,
    localparam int MADDR_W = 30 - OFFSET_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [31:0]        ADDRESS,
    input  logic [31:0]        WRITEDATA,
    output logic [31:0]        READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [MADDR_W-1:0] MEM_ADDRESS,
    output logic [BLK_W-1:0]   MEM_WRITEDATA,
    input  logic [BLK_W-1:0]   MEM_READDATA,
    input  logic               MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        HIT_COUNT,
    output logic [31:0]        MISS_COUNT
`endif
);
    typedef enum logic [1:0] {IDLE, WBACK, FETCH, UPDATE} state_t;
    state_t state, next_state;
    logic [BLK_W-1:0] data_mem [NUM_SETS];
    logic [TAG_W-1:0] tag_mem [NUM_SETS];
    logic [NUM_SETS-1:0] valid, dirty;
    logic [TAG_W-1:0] tag, miss_tag;
    logic [INDEX_W-1:0] index, miss_index;
    logic [OFFSET_W-1:0] offset;
    logic [BLK_W-1:0] fill_buf;
    logic request, hit, miss, write_hit, unused;

    assign offset = ADDRESS[2 +: OFFSET_W];
    assign index = ADDRESS[2 + OFFSET_W +: INDEX_W];
    assign tag = ADDRESS[31 -: TAG_W];
    assign unused = ^ADDRESS[1:0];
    assign request = READ | WRITE;
    assign hit = valid[index] && tag_mem[index] == tag;
    assign miss = state == IDLE && request && !hit;
    assign write_hit = state == IDLE && WRITE && hit;
    assign READDATA = hit ? data_mem[index][{offset, 5'd0} +: 32] : '0;
    assign BUSYWAIT = !RESET && request && (!hit || state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else state <= next_state;
    end

    // Miss address is latched so strobes and MEM_ADDRESS hold even if the request drops.
    always_comb begin
        next_state = state;
        MEM_READ = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_ADDRESS = {miss_tag, miss_index};
        MEM_WRITEDATA = data_mem[miss_index];
        case (state)
            IDLE: if (miss) next_state = dirty[index] ? WBACK : FETCH;
            WBACK: begin
                MEM_WRITE = 1'b1;
                MEM_ADDRESS = {tag_mem[miss_index], miss_index};
                if (!MEM_BUSYWAIT) next_state = FETCH;
            end
            FETCH: begin
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) next_state = UPDATE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == UPDATE) begin
            valid[miss_index] <= 1'b1;
            dirty[miss_index] <= 1'b0;
        end else if (write_hit) begin
            dirty[index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (miss) begin
            miss_tag <= tag;
            miss_index <= index;
        end
        if (state == FETCH && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
        if (state == UPDATE) begin
            data_mem[miss_index] <= fill_buf;
            tag_mem[miss_index] <= miss_tag;
        end else if (write_hit) begin
            data_mem[index][{offset, 5'd0} +: 32] <= WRITEDATA;
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that completes a miss follows UPDATE and is already counted as a miss.
    logic replay;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            HIT_COUNT <= '0;
            MISS_COUNT <= '0;
            replay <= 1'b0;
        end else begin
            replay <= state == UPDATE;
            if (request && !BUSYWAIT && !replay) HIT_COUNT <= HIT_COUNT + 32'd1;
            if (miss) MISS_COUNT <= MISS_COUNT + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: scoreboard bench for dcache_controller with a wait-state block memory model.
module tb_dcache_controller;
    logic CLK = 1'b0;
    logic RESET, READ, WRITE;
    logic [31:0] ADDRESS, WRITEDATA, READDATA;
    logic BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0] MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
    logic [31:0] HIT_COUNT, MISS_COUNT;
`endif

    typedef struct {bit wr; logic [27:0] addr; logic [127:0] data;} txn_t;
    typedef struct {bit chk_rd; logic [31:0] rdata; int stalls; int rd_cyc; int wr_cyc;} exp_t;
    txn_t mem_log[$];
    exp_t exp_q[$];
    logic [127:0] mem_arr [256];
    logic [31:0] ref_mem [1024];
    bit m_valid [8];
    bit m_dirty [8];
    logic [24:0] m_tag [8];
    int mem_wait = 0;
    int wait_left = 0;
    int vectors = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dcache_controller dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
    );

    // Memory: busy for mem_wait edges per transfer, completes on the next edge.
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && wait_left != 0;
    assign MEM_READDATA = mem_arr[MEM_ADDRESS[7:0]];

    always @(posedge CLK) begin
        if (RESET || !(MEM_READ || MEM_WRITE)) wait_left <= mem_wait;
        else if (wait_left != 0) wait_left <= wait_left - 1;
        else begin
            wait_left <= mem_wait;
            if (MEM_WRITE) mem_arr[MEM_ADDRESS[7:0]] = MEM_WRITEDATA;
            mem_log.push_back('{MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA});
        end
    end

    function automatic logic [31:0] init_word(int w);
        return {16'hC0DE, w[15:0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    function automatic exp_t model(bit rd, bit wr, logic [31:0] addr, logic [31:0] data);
        exp_t e;
        int idx = int'(addr[6:4]);
        logic [24:0] tg = addr[31:7];
        bit miss, drt;
        miss = !(m_valid[idx] && m_tag[idx] == tg);
        drt = miss && m_valid[idx] && m_dirty[idx];
        if (miss) begin
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) m_dirty[idx] = 1'b1;
        e.chk_rd = rd && !wr;
        e.rdata = ref_mem[addr[11:2]];
        if (wr) ref_mem[addr[11:2]] = data;
        e.stalls = !miss ? 0 : drt ? 2 * mem_wait + 4 : mem_wait + 3;
        e.rd_cyc = miss ? mem_wait + 1 : 0;
        e.wr_cyc = drt ? mem_wait + 1 : 0;
        return e;
    endfunction

    // Called just after a posedge; leaves just after the accepting posedge.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int stalls = 0, rd_cyc = 0, wr_cyc = 0, moved = 0;
        bit prev_rd = 1'b0, prev_wr = 1'b0;
        logic [27:0] prev_addr = '0;
        exp_q.push_back(model(rd, wr, addr, data));
        READ = rd;
        WRITE = wr;
        ADDRESS = addr;
        WRITEDATA = data;
        @(negedge CLK);
        while (BUSYWAIT === 1'b1 && stalls < 200) begin
            if (MEM_READ === 1'b1) begin
                rd_cyc++;
                if (prev_rd && MEM_ADDRESS !== prev_addr) moved++;
            end
            if (MEM_WRITE === 1'b1) begin
                wr_cyc++;
                if (prev_wr && MEM_ADDRESS !== prev_addr) moved++;
            end
            prev_rd = MEM_READ;
            prev_wr = MEM_WRITE;
            prev_addr = MEM_ADDRESS;
            stalls++;
            @(negedge CLK);
        end
        e = exp_q.pop_front();
        vectors++;
        if (stalls != e.stalls) begin
            errors++;
            $display("FAIL stalls addr=%h got %0d expected %0d", addr, stalls, e.stalls);
        end
        vectors++;
        if (rd_cyc != e.rd_cyc) begin
            errors++;
            $display("FAIL mem_read_cycles addr=%h got %0d expected %0d", addr, rd_cyc, e.rd_cyc);
        end
        vectors++;
        if (wr_cyc != e.wr_cyc) begin
            errors++;
            $display("FAIL mem_write_cycles addr=%h got %0d expected %0d", addr, wr_cyc, e.wr_cyc);
        end
        vectors++;
        if (moved != 0) begin
            errors++;
            $display("FAIL mem_address_stable addr=%h got %0d changes expected 0", addr, moved);
        end
        if (e.chk_rd) begin
            vectors++;
            if (READDATA !== e.rdata) begin
                errors++;
                $display("FAIL readdata addr=%h got %h expected %h", addr, READDATA, e.rdata);
            end
        end
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        READ = 1'b1;
        ADDRESS = 32'h40;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vectors += 4;
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b expected 0", BUSYWAIT); end
        if (MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b expected 0", MEM_READ); end
        if (MEM_WRITE !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b expected 0", MEM_WRITE); end
        if (READDATA !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h expected 0", READDATA); end
`ifdef DCACHE_STATS_EN
        vectors += 2;
        if (HIT_COUNT !== 32'h0) begin errors++; $display("FAIL reset_hit_count got %0d expected 0", HIT_COUNT); end
        if (MISS_COUNT !== 32'h0) begin errors++; $display("FAIL reset_miss_count got %0d expected 0", MISS_COUNT); end
`endif
        RESET = 1'b0;
        READ = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_read_miss;
        txn_t t;
        mem_log.delete();
        do_req(1'b1, 1'b0, 32'h40, 32'h0);
        vectors++;
        if (mem_log.size() != 1) begin
            errors++;
            $display("FAIL read_miss_txns got %0d expected 1", mem_log.size());
        end else begin
            t = mem_log[0];
            vectors++;
            if (t.wr !== 1'b0 || t.addr !== 28'h4) begin
                errors++;
                $display("FAIL read_miss_fetch got wr=%b addr=%h expected wr=0 addr=4", t.wr, t.addr);
            end
        end
    endtask

    task automatic test_write_hit;
        mem_log.delete();
        do_req(1'b0, 1'b1, 32'h44, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h44, 32'h0);
        vectors++;
        if (mem_log.size() != 0) begin
            errors++;
            $display("FAIL write_hit_txns got %0d expected 0", mem_log.size());
        end
    endtask

    task automatic test_dirty_evict;
        txn_t t;
        mem_log.delete();
        do_req(1'b1, 1'b0, 32'h440, 32'h0);
        vectors++;
        if (mem_log.size() != 2) begin
            errors++;
            $display("FAIL evict_txns got %0d expected 2", mem_log.size());
        end else begin
            t = mem_log[0];
            vectors++;
            if (t.wr !== 1'b1 || t.addr !== 28'h4 || t.data[63:32] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL evict_wback got wr=%b addr=%h word1=%h expected wr=1 addr=4 word1=deadbeef",
                         t.wr, t.addr, t.data[63:32]);
            end
            t = mem_log[1];
            vectors++;
            if (t.wr !== 1'b0 || t.addr !== 28'h44) begin
                errors++;
                $display("FAIL evict_fetch got wr=%b addr=%h expected wr=0 addr=44", t.wr, t.addr);
            end
        end
`ifdef DCACHE_STATS_EN
        vectors += 2;
        if (HIT_COUNT !== 32'd2) begin errors++; $display("FAIL stats_hit_count got %0d expected 2", HIT_COUNT); end
        if (MISS_COUNT !== 32'd2) begin errors++; $display("FAIL stats_miss_count got %0d expected 2", MISS_COUNT); end
`endif
    endtask

    task automatic test_mem_wait;
        mem_wait = 5;
        do_req(1'b1, 1'b0, 32'h80, 32'h0);
        mem_wait = 0;
    endtask

    task automatic test_reset_mid_fetch;
        mem_wait = 3;
        READ = 1'b1;
        WRITE = 1'b0;
        ADDRESS = 32'hC0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (MEM_READ !== 1'b1) begin errors++; $display("FAIL midfetch_mem_read got %b expected 1", MEM_READ); end
        #1 RESET = 1'b1;
        #1;
        vectors += 3;
        if (MEM_READ !== 1'b0) begin errors++; $display("FAIL midreset_mem_read got %b expected 0", MEM_READ); end
        if (MEM_WRITE !== 1'b0) begin errors++; $display("FAIL midreset_mem_write got %b expected 0", MEM_WRITE); end
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midreset_busywait got %b expected 0", BUSYWAIT); end
        @(negedge CLK);
        RESET = 1'b0;
        READ = 1'b0;
        mem_wait = 0;
        model_reset();
        @(posedge CLK);
        #1;
        do_req(1'b1, 1'b0, 32'h40, 32'h0);
        do_req(1'b1, 1'b0, 32'h44, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        int k;
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, 255) * 4;
            k = $urandom_range(0, 3);
            mem_wait = $urandom_range(0, 2);
            do_req(k != 2, k >= 2, a, $urandom);
        end
    endtask

    initial begin
        RESET = 1'b1;
        READ = 1'b0;
        WRITE = 1'b0;
        ADDRESS = '0;
        WRITEDATA = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 4; j++) mem_arr[i][32*j +: 32] = init_word(4 * i + j);
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_mem_wait();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
